// File: rtl/mat_inv_sched.sv
// mat_inv_sched: sequences the LU engine, then the triangular inverter on U and on L.
// Owns the shared row-read port and reports done, timeout error and read conflicts.
module mat_inv_sched #(
  parameter int SIZE        = 32,
  parameter int START_CYC   = 2,
  parameter int FLUSH_CYC   = 4,
  parameter int TIMEOUT_CYC = 200000,
  localparam int AW         = $clog2(SIZE)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [1:0]    err_phase_o,
  output logic [1:0]    phase_o,
  output logic          lu_start_o,
  output logic          lu_flush_o,
  input  logic          lu_ready_i,
  output logic          inv_start_o,
  output logic          inv_flush_o,
  input  logic          inv_ready_i,
  input  logic          lu_rd_req_i,
  input  logic [AW-1:0] lu_rd_addr_i,
  input  logic          inv_rd_req_i,
  input  logic [AW-1:0] inv_rd_addr_i,
  output logic          mem_rd_en_o,
  output logic [AW-1:0] mem_rd_addr_o,
  output logic [1:0]    mem_bank_o,
  output logic          conflict_o
);

  localparam int CMAX = (START_CYC > FLUSH_CYC) ? START_CYC : FLUSH_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_CYC - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    IDLE, LU_GO, LU_ACK, LU_RUN, U_GO, U_ACK, U_RUN,
    L_FLUSH, L_GO, L_ACK, L_RUN, DONE, ERR, ABORT
  } state_e;

  // Phase code doubles as the timeout window: L_FLUSH belongs to the LINV phase.
  function automatic logic [1:0] phaseOf(state_e s);
    case (s)
      LU_GO, LU_ACK, LU_RUN:       phaseOf = 2'd1;
      U_GO, U_ACK, U_RUN:          phaseOf = 2'd2;
      L_FLUSH, L_GO, L_ACK, L_RUN: phaseOf = 2'd3;
      default:                     phaseOf = 2'd0;
    endcase
  endfunction

  function automatic logic isIdle(state_e s);
    isIdle = (s == IDLE) || (s == DONE) || (s == ERR);
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmoCnt_q, tmoCnt_d;
  logic            tmoAbort_q, tmoAbort_d;
  logic [1:0]      tmoPhase_q, tmoPhase_d;
  logic            conflict_q, conflict_d;
  logic            tmoHit;
  logic            startAcc;
  logic            nonOwnerReq;

  logic            busy_d, done_d, err_d, luStart_d, luFlush_d, invStart_d, invFlush_d;
  logic [1:0]      errPhase_d, phase_d;

  assign startAcc   = isIdle(state_q) && start_i;
  assign conflict_o = conflict_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tmoCnt_q   <= '0;
      tmoAbort_q <= 1'b0;
      tmoPhase_q <= 2'd0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmoCnt_q   <= tmoCnt_d;
      tmoAbort_q <= tmoAbort_d;
      tmoPhase_q <= tmoPhase_d;
      conflict_q <= conflict_d;
    end
  end

  // An engine that already dropped ready on the last GO cycle skips ACK.
  always_comb begin
    state_d = state_q;
    tmoHit  = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: if (start_i) state_d = LU_GO;
      LU_GO:   if (cnt_q == START_LAST) state_d = lu_ready_i ? LU_ACK : LU_RUN;
      LU_ACK:  if (!lu_ready_i) state_d = LU_RUN;
      LU_RUN:  if (lu_ready_i) state_d = U_GO;
      U_GO:    if (cnt_q == START_LAST) state_d = inv_ready_i ? U_ACK : U_RUN;
      U_ACK:   if (!inv_ready_i) state_d = U_RUN;
      U_RUN:   if (inv_ready_i) state_d = L_FLUSH;
      L_FLUSH: if (cnt_q == FLUSH_LAST) state_d = L_GO;
      L_GO:    if (cnt_q == START_LAST) state_d = inv_ready_i ? L_ACK : L_RUN;
      L_ACK:   if (!inv_ready_i) state_d = L_RUN;
      L_RUN:   if (inv_ready_i) state_d = DONE;
      ABORT:   if (cnt_q == FLUSH_LAST) state_d = tmoAbort_q ? ERR : IDLE;
      default: state_d = IDLE;
    endcase
    if (phaseOf(state_q) != 2'd0) begin
      if (abort_i) begin
        state_d = ABORT;
      end else if (tmoCnt_q == TMO_LAST) begin
        state_d = ABORT;
        tmoHit  = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) &&
        (state_q inside {LU_GO, U_GO, L_GO, L_FLUSH, ABORT}))
      cnt_d = cnt_q + 1'b1;

    tmoCnt_d = '0;
    if ((phaseOf(state_d) == phaseOf(state_q)) && (phaseOf(state_q) != 2'd0))
      tmoCnt_d = tmoCnt_q + 1'b1;

    tmoAbort_d = tmoAbort_q;
    tmoPhase_d = tmoPhase_q;
    if (startAcc) begin
      tmoAbort_d = 1'b0;
      tmoPhase_d = 2'd0;
    end else if (tmoHit) begin
      tmoAbort_d = 1'b1;
      tmoPhase_d = phaseOf(state_q);
    end

    conflict_d = startAcc ? 1'b0 : (conflict_q | nonOwnerReq);
  end

  // Outputs are decoded from the next state and registered so they line up with state_q.
  always_comb begin
    busy_d     = !isIdle(state_d);
    done_d     = (state_d == DONE) && (state_q != DONE);
    err_d      = (state_d == ERR);
    errPhase_d = (state_d == ERR) ? tmoPhase_q : 2'd0;
    phase_d    = phaseOf(state_d);
    luStart_d  = (state_d == LU_GO);
    invStart_d = (state_d == U_GO) || (state_d == L_GO);
    luFlush_d  = (state_d == ABORT);
    invFlush_d = (state_d == ABORT) || (state_d == L_FLUSH);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      err_phase_o <= 2'd0;
      phase_o     <= 2'd0;
      lu_start_o  <= 1'b0;
      lu_flush_o  <= 1'b0;
      inv_start_o <= 1'b0;
      inv_flush_o <= 1'b0;
    end else begin
      busy_o      <= busy_d;
      done_o      <= done_d;
      err_o       <= err_d;
      err_phase_o <= errPhase_d;
      phase_o     <= phase_d;
      lu_start_o  <= luStart_d;
      lu_flush_o  <= luFlush_d;
      inv_start_o <= invStart_d;
      inv_flush_o <= invFlush_d;
    end
  end

  // Zero-latency read steering; during ABORT nobody owns the port, so any request conflicts.
  always_comb begin
    mem_rd_en_o   = 1'b0;
    mem_rd_addr_o = '0;
    mem_bank_o    = 2'd0;
    nonOwnerReq   = 1'b0;
    case (phaseOf(state_q))
      2'd1: begin
        mem_rd_en_o   = lu_rd_req_i;
        mem_rd_addr_o = lu_rd_addr_i;
        mem_bank_o    = 2'd0;
        nonOwnerReq   = inv_rd_req_i;
      end
      2'd2: begin
        mem_rd_en_o   = inv_rd_req_i;
        mem_rd_addr_o = inv_rd_addr_i;
        mem_bank_o    = 2'd1;
        nonOwnerReq   = lu_rd_req_i;
      end
      2'd3: begin
        mem_rd_en_o   = inv_rd_req_i;
        mem_rd_addr_o = inv_rd_addr_i;
        mem_bank_o    = 2'd2;
        nonOwnerReq   = lu_rd_req_i;
      end
      default: begin
        nonOwnerReq = !isIdle(state_q) && (lu_rd_req_i || inv_rd_req_i);
      end
    endcase
  end

endmodule

// File: tb/tb_mat_inv_sched.sv
// tb_mat_inv_sched: self-checking bench for mat_inv_sched with behavioural LU and
// triangular-inverter engine models (ready drops 3 cycles after start, low 20 cycles).
`timescale 1ns/1ps
module tb_mat_inv_sched;

  localparam int SIZE        = 8;
  localparam int AW          = 3;
  localparam int START_CYC   = 2;
  localparam int FLUSH_CYC   = 4;
  localparam int TIMEOUT_CYC = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i, abort_i;
  logic          busy_o, done_o, err_o;
  logic [1:0]    err_phase_o, phase_o;
  logic          lu_start_o, lu_flush_o, lu_ready_i;
  logic          inv_start_o, inv_flush_o, inv_ready_i;
  logic          lu_rd_req_i, inv_rd_req_i;
  logic [AW-1:0] lu_rd_addr_i, inv_rd_addr_i;
  logic          mem_rd_en_o;
  logic [AW-1:0] mem_rd_addr_o;
  logic [1:0]    mem_bank_o;
  logic          conflict_o;

  int checks   = 0;
  int failures = 0;

  int luCnt  = 0;
  int invCnt = 0;
  bit invNeverReady = 1'b0;

  mat_inv_sched #(
    .SIZE(SIZE), .START_CYC(START_CYC), .FLUSH_CYC(FLUSH_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_phase_o(err_phase_o),
    .phase_o(phase_o), .lu_start_o(lu_start_o), .lu_flush_o(lu_flush_o),
    .lu_ready_i(lu_ready_i), .inv_start_o(inv_start_o), .inv_flush_o(inv_flush_o),
    .inv_ready_i(inv_ready_i), .lu_rd_req_i(lu_rd_req_i), .lu_rd_addr_i(lu_rd_addr_i),
    .inv_rd_req_i(inv_rd_req_i), .inv_rd_addr_i(inv_rd_addr_i),
    .mem_rd_en_o(mem_rd_en_o), .mem_rd_addr_o(mem_rd_addr_o),
    .mem_bank_o(mem_bank_o), .conflict_o(conflict_o)
  );

  always #5 clk = ~clk;

  // Engine models react on the falling edge so the DUT sees stable ready levels.
  always @(negedge clk) begin
    if (rst || lu_flush_o) begin
      lu_ready_i = 1'b1;
      luCnt      = 0;
    end else if (luCnt == 0) begin
      if (lu_start_o) luCnt = 1;
    end else begin
      luCnt++;
      if (luCnt == 3) lu_ready_i = 1'b0;
      if (luCnt == 23) begin lu_ready_i = 1'b1; luCnt = 0; end
    end
  end

  always @(negedge clk) begin
    if (rst || inv_flush_o) begin
      inv_ready_i = 1'b1;
      invCnt      = 0;
    end else if (invCnt == 0) begin
      if (inv_start_o) invCnt = 1;
    end else begin
      if (!(invNeverReady && invCnt >= 3)) invCnt++;
      if (invCnt == 3) inv_ready_i = 1'b0;
      if (invCnt == 23) begin inv_ready_i = 1'b1; invCnt = 0; end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    lu_rd_req_i = 1'b1; inv_rd_req_i = 1'b1; lu_rd_addr_i = 3'd6; inv_rd_addr_i = 3'd7;
    repeat (3) step();
    checks++;
    if ({busy_o, done_o, err_o, err_phase_o, phase_o, lu_start_o, lu_flush_o, inv_start_o,
         inv_flush_o, mem_rd_en_o, mem_rd_addr_o, mem_bank_o, conflict_o} !== '0)
      begin failures++; $display("[TB] FAIL reset_outputs: got busy=%b done=%b err=%b ph=%0d en=%b addr=%0d bank=%0d conf=%b, required all 0",
        busy_o, done_o, err_o, phase_o, mem_rd_en_o, mem_rd_addr_o, mem_bank_o, conflict_o); end
    rst = 1'b0;
    step();
    checks++;
    if (conflict_o !== 1'b0 || busy_o !== 1'b0 || mem_rd_en_o !== 1'b0)
      begin failures++; $display("[TB] FAIL idle_requests: got conf=%b busy=%b en=%b, required 0 0 0", conflict_o, busy_o, mem_rd_en_o); end
    lu_rd_req_i = 1'b0; inv_rd_req_i = 1'b0; lu_rd_addr_i = '0; inv_rd_addr_i = '0;
  endtask

  task automatic test_nominal();
    int expPhaseQ[$];
    int expBankQ[$];
    int lastPhase, doneCnt, cyc, doneAt, expP, expB;
    expPhaseQ = {1, 2, 3};
    expBankQ  = {0, 1, 2};
    lastPhase = 0; doneCnt = 0; doneAt = -1;
    start_i = 1'b1; step(); start_i = 1'b0;
    for (cyc = 0; cyc < 400; cyc++) begin
      if (phase_o != 2'(lastPhase) && phase_o != 2'd0) begin
        checks++;
        if (expPhaseQ.size() == 0) begin
          failures++; $display("[TB] FAIL nominal_extra_phase: got phase %0d, required none", phase_o);
        end else begin
          expP = expPhaseQ.pop_front();
          expB = expBankQ.pop_front();
          if (32'(phase_o) !== expP) begin failures++; $display("[TB] FAIL nominal_phase: got %0d required %0d", phase_o, expP); end
          checks++;
          if (32'(mem_bank_o) !== expB) begin failures++; $display("[TB] FAIL nominal_bank: got %0d required %0d", mem_bank_o, expB); end
        end
      end
      lastPhase = int'(phase_o);
      if (done_o === 1'b1) begin doneCnt++; if (doneAt < 0) doneAt = cyc; end
      if (doneAt >= 0 && cyc >= doneAt + 5) break;
      step();
    end
    checks++;
    if (doneCnt != 1) begin failures++; $display("[TB] FAIL nominal_done_pulses: got %0d required 1", doneCnt); end
    checks++;
    if (expPhaseQ.size() != 0) begin failures++; $display("[TB] FAIL nominal_phases_left: got %0d pending required 0", expPhaseQ.size()); end
    checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b0 || phase_o !== 2'd0)
      begin failures++; $display("[TB] FAIL nominal_final: got busy=%b err=%b ph=%0d required 0 0 0", busy_o, err_o, phase_o); end
  endtask

  task automatic test_flush_gap();
    int expInvStartQ[$];
    int expInvFlushQ[$];
    int expLuStartQ[$];
    int invStartRun, invFlushRun, luStartRun, cyc, expv;
    bit prevInvFlush, luFlushSeen, doneSeen;
    expInvStartQ = {2, 2}; expInvFlushQ = {4}; expLuStartQ = {2};
    invStartRun = 0; invFlushRun = 0; luStartRun = 0;
    prevInvFlush = 1'b0; luFlushSeen = 1'b0; doneSeen = 1'b0;
    start_i = 1'b1; step(); start_i = 1'b0;
    for (cyc = 0; cyc < 400 && !doneSeen; cyc++) begin
      if (inv_start_o === 1'b1) invStartRun++;
      else if (invStartRun > 0) begin
        checks++;
        expv = (expInvStartQ.size() > 0) ? expInvStartQ.pop_front() : -1;
        if (invStartRun != expv) begin failures++; $display("[TB] FAIL inv_start_len: got %0d required %0d", invStartRun, expv); end
        invStartRun = 0;
      end
      if (inv_flush_o === 1'b1) invFlushRun++;
      else if (invFlushRun > 0) begin
        checks++;
        expv = (expInvFlushQ.size() > 0) ? expInvFlushQ.pop_front() : -1;
        if (invFlushRun != expv) begin failures++; $display("[TB] FAIL inv_flush_len: got %0d required %0d", invFlushRun, expv); end
        invFlushRun = 0;
      end
      if (lu_start_o === 1'b1) luStartRun++;
      else if (luStartRun > 0) begin
        checks++;
        expv = (expLuStartQ.size() > 0) ? expLuStartQ.pop_front() : -1;
        if (luStartRun != expv) begin failures++; $display("[TB] FAIL lu_start_len: got %0d required %0d", luStartRun, expv); end
        luStartRun = 0;
      end
      if (prevInvFlush && inv_flush_o !== 1'b1) begin
        checks++;
        if (inv_start_o !== 1'b1) begin failures++; $display("[TB] FAIL flush_to_start_gap: got inv_start=%b required 1", inv_start_o); end
      end
      if (lu_flush_o === 1'b1) luFlushSeen = 1'b1;
      prevInvFlush = (inv_flush_o === 1'b1);
      if (done_o === 1'b1) doneSeen = 1'b1;
      else step();
    end
    checks++;
    if (!doneSeen || expInvStartQ.size() != 0 || expInvFlushQ.size() != 0 || expLuStartQ.size() != 0)
      begin failures++; $display("[TB] FAIL flush_gap_complete: got done=%b pending=%0d/%0d/%0d required 1 0/0/0",
        doneSeen, expInvStartQ.size(), expInvFlushQ.size(), expLuStartQ.size()); end
    checks++;
    if (luFlushSeen) begin failures++; $display("[TB] FAIL flush_gap_lu_flush: got 1 required 0"); end
  endtask

  task automatic test_timeout();
    int luFlushRun, invFlushRun, flushDiff, cyc, invStartAt, flushAt;
    bit doneSeen;
    luFlushRun = 0; invFlushRun = 0; flushDiff = 0; invStartAt = -1; flushAt = -1; doneSeen = 1'b0;
    invNeverReady = 1'b1;
    start_i = 1'b1; step(); start_i = 1'b0;
    for (cyc = 0; cyc < 400 && busy_o === 1'b1; cyc++) begin
      if (inv_start_o === 1'b1 && invStartAt < 0) invStartAt = cyc;
      if (lu_flush_o === 1'b1 && flushAt < 0) flushAt = cyc;
      if (lu_flush_o === 1'b1) luFlushRun++;
      if (inv_flush_o === 1'b1) invFlushRun++;
      if (lu_flush_o !== inv_flush_o) flushDiff++;
      if (done_o === 1'b1) doneSeen = 1'b1;
      step();
    end
    invNeverReady = 1'b0;
    checks++;
    if (luFlushRun != FLUSH_CYC || invFlushRun != FLUSH_CYC || flushDiff != 0)
      begin failures++; $display("[TB] FAIL timeout_flush: got lu=%0d inv=%0d diff=%0d required 4 4 0", luFlushRun, invFlushRun, flushDiff); end
    checks++;
    if (flushAt - invStartAt != TIMEOUT_CYC)
      begin failures++; $display("[TB] FAIL timeout_latency: got %0d cycles required %0d", flushAt - invStartAt, TIMEOUT_CYC); end
    checks++;
    if (err_o !== 1'b1 || err_phase_o !== 2'd2 || busy_o !== 1'b0 || doneSeen)
      begin failures++; $display("[TB] FAIL timeout_status: got err=%b phase=%0d busy=%b done=%b required 1 2 0 0",
        err_o, err_phase_o, busy_o, doneSeen); end
    repeat (3) step();
    checks++;
    if (err_o !== 1'b1 || err_phase_o !== 2'd2)
      begin failures++; $display("[TB] FAIL timeout_sticky: got err=%b phase=%0d required 1 2", err_o, err_phase_o); end
  endtask

  task automatic test_abort();
    int expPhaseQ[$];
    int luFlushRun, invFlushRun, cyc, lastPhase, expP, doneCnt;
    bit doneSeen, startSeen, reached;
    luFlushRun = 0; invFlushRun = 0; doneSeen = 1'b0; startSeen = 1'b0; reached = 1'b0;
    abort_i = 1'b1; step(); abort_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || lu_flush_o !== 1'b0 || err_o !== 1'b1)
      begin failures++; $display("[TB] FAIL abort_ignored_idle: got busy=%b flush=%b err=%b required 0 0 1", busy_o, lu_flush_o, err_o); end
    start_i = 1'b1; step(); start_i = 1'b0;
    checks++;
    if (err_o !== 1'b0 || err_phase_o !== 2'd0 || phase_o !== 2'd1)
      begin failures++; $display("[TB] FAIL restart_clears_err: got err=%b ephase=%0d ph=%0d required 0 0 1", err_o, err_phase_o, phase_o); end
    for (cyc = 0; cyc < 60 && !reached; cyc++) begin
      if (phase_o === 2'd1 && lu_ready_i === 1'b0) reached = 1'b1;
      else step();
    end
    checks++;
    if (!reached) begin failures++; $display("[TB] FAIL abort_reach_lu_run: got timeout required LU running"); end
    repeat (5) step();
    abort_i = 1'b1; step(); abort_i = 1'b0;
    for (cyc = 0; cyc < 40 && busy_o === 1'b1; cyc++) begin
      if (lu_flush_o === 1'b1) luFlushRun++;
      if (inv_flush_o === 1'b1) invFlushRun++;
      if (lu_start_o === 1'b1 || inv_start_o === 1'b1) startSeen = 1'b1;
      if (done_o === 1'b1) doneSeen = 1'b1;
      step();
    end
    checks++;
    if (luFlushRun != FLUSH_CYC || invFlushRun != FLUSH_CYC || startSeen)
      begin failures++; $display("[TB] FAIL abort_flush: got lu=%0d inv=%0d start=%b required 4 4 0", luFlushRun, invFlushRun, startSeen); end
    checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b0 || phase_o !== 2'd0 || doneSeen || done_o !== 1'b0)
      begin failures++; $display("[TB] FAIL abort_final: got busy=%b err=%b ph=%0d done=%b required 0 0 0 0", busy_o, err_o, phase_o, doneSeen); end
    expPhaseQ = {1, 2, 3};
    start_i = 1'b1; abort_i = 1'b1; step(); start_i = 1'b0; abort_i = 1'b0;
    checks++;
    if (phase_o !== 2'd1 || lu_flush_o !== 1'b0)
      begin failures++; $display("[TB] FAIL start_beats_abort: got ph=%0d flush=%b required 1 0", phase_o, lu_flush_o); end
    lastPhase = 0; doneCnt = 0;
    for (cyc = 0; cyc < 400 && doneCnt == 0; cyc++) begin
      if (phase_o != 2'(lastPhase) && phase_o != 2'd0) begin
        checks++;
        expP = (expPhaseQ.size() > 0) ? expPhaseQ.pop_front() : -1;
        if (32'(phase_o) !== expP) begin failures++; $display("[TB] FAIL rerun_phase: got %0d required %0d", phase_o, expP); end
      end
      lastPhase = int'(phase_o);
      if (done_o === 1'b1) doneCnt++;
      else step();
    end
    checks++;
    if (doneCnt != 1 || expPhaseQ.size() != 0)
      begin failures++; $display("[TB] FAIL rerun_done: got done=%0d pending=%0d required 1 0", doneCnt, expPhaseQ.size()); end
  endtask

  task automatic test_arbitration();
    int cyc;
    bit doneSeen, reached;
    doneSeen = 1'b0; reached = 1'b0;
    step();
    start_i = 1'b1; step(); start_i = 1'b0;
    lu_rd_req_i = 1'b1; lu_rd_addr_i = 3'd2; inv_rd_req_i = 1'b1; inv_rd_addr_i = 3'd5;
    #1;
    checks++;
    if (mem_rd_en_o !== 1'b1 || mem_rd_addr_o !== 3'd2 || mem_bank_o !== 2'd0)
      begin failures++; $display("[TB] FAIL arb_lu_owner: got en=%b addr=%0d bank=%0d required 1 2 0", mem_rd_en_o, mem_rd_addr_o, mem_bank_o); end
    step();
    lu_rd_req_i = 1'b0; inv_rd_req_i = 1'b0;
    checks++;
    if (conflict_o !== 1'b1) begin failures++; $display("[TB] FAIL arb_conflict_set: got %b required 1", conflict_o); end
    for (cyc = 0; cyc < 60 && !reached; cyc++) begin
      if (phase_o === 2'd2) reached = 1'b1;
      else step();
    end
    inv_rd_req_i = 1'b1; inv_rd_addr_i = 3'd3;
    #1;
    checks++;
    if (!reached || mem_rd_en_o !== 1'b1 || mem_rd_addr_o !== 3'd3 || mem_bank_o !== 2'd1)
      begin failures++; $display("[TB] FAIL arb_inv_owner: got reached=%b en=%b addr=%0d bank=%0d required 1 1 3 1",
        reached, mem_rd_en_o, mem_rd_addr_o, mem_bank_o); end
    inv_rd_req_i = 1'b0; lu_rd_req_i = 1'b1; lu_rd_addr_i = 3'd1;
    #1;
    checks++;
    if (mem_rd_en_o !== 1'b0) begin failures++; $display("[TB] FAIL arb_lu_blocked: got en=%b required 0", mem_rd_en_o); end
    step();
    lu_rd_req_i = 1'b0;
    for (cyc = 0; cyc < 200 && !doneSeen; cyc++) begin
      if (done_o === 1'b1) doneSeen = 1'b1;
      else step();
    end
    checks++;
    if (!doneSeen || conflict_o !== 1'b1)
      begin failures++; $display("[TB] FAIL arb_conflict_sticky: got done=%b conf=%b required 1 1", doneSeen, conflict_o); end
    start_i = 1'b1; step(); start_i = 1'b0;
    checks++;
    if (conflict_o !== 1'b0) begin failures++; $display("[TB] FAIL arb_conflict_clear: got %b required 0", conflict_o); end
  endtask

  task automatic test_reset_midflow();
    int cyc, flushSeen, busySeen;
    bit reached;
    reached = 1'b0; flushSeen = 0; busySeen = 0;
    for (cyc = 0; cyc < 200 && !reached; cyc++) begin
      if (phase_o === 2'd3 && inv_ready_i === 1'b0) reached = 1'b1;
      else step();
    end
    step();
    checks++;
    if (!reached || phase_o !== 2'd3) begin failures++; $display("[TB] FAIL midflow_reach_l_run: got reached=%b ph=%0d required 1 3", reached, phase_o); end
    rst = 1'b1; step();
    checks++;
    if ({busy_o, done_o, err_o, err_phase_o, phase_o, lu_start_o, lu_flush_o, inv_start_o,
         inv_flush_o, mem_rd_en_o, mem_rd_addr_o, mem_bank_o, conflict_o} !== '0)
      begin failures++; $display("[TB] FAIL midflow_reset_outputs: got busy=%b ph=%0d bank=%0d flush=%b/%b required all 0",
        busy_o, phase_o, mem_bank_o, lu_flush_o, inv_flush_o); end
    step();
    rst = 1'b0;
    for (cyc = 0; cyc < 10; cyc++) begin
      if (lu_flush_o === 1'b1 || inv_flush_o === 1'b1) flushSeen++;
      if (busy_o === 1'b1) busySeen++;
      step();
    end
    checks++;
    if (flushSeen != 0 || busySeen != 0)
      begin failures++; $display("[TB] FAIL midflow_no_flush: got flush=%0d busy=%0d required 0 0", flushSeen, busySeen); end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_nominal();
    test_flush_gap();
    test_timeout();
    test_abort();
    test_arbitration();
    test_reset_midflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
